// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: walks the three LED channels around a hue wheel.
// Six ramp phases step one channel's duty linearly while the other two are
// held at full scale or off. A divide-by-TIME prescaler paces the ramp and a
// shared free-running PWM counter turns duty values into pin levels.
// Optional feature: define RGB_FADE_PAUSE_EN to add a `pause` input that
// freezes the wheel (PWM keeps running so the held colour stays visible).
module rgb_fade_sequencer #(
  parameter int TIME  = 300,
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
`ifdef RGB_FADE_PAUSE_EN
  input  logic       pause,
`endif
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic [2:0] phase,
  output logic       active,
  output logic       wrap
);

  localparam int PW = $clog2(TIME);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TIME - 1);
  localparam logic [WIDTH-1:0] M          = WIDTH'((1 << WIDTH) - 1);
  localparam logic [WIDTH-1:0] PC_LAST    = WIDTH'((1 << WIDTH) - 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] pc;
  logic [2:0]       p;
  logic [WIDTH-1:0] duty_r, duty_g, duty_b;
  logic             hold;
  logic             strobe;

`ifdef RGB_FADE_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign strobe = (presc == PRESC_LAST);
  assign phase  = p;

  // Duty table: which channel ramps up/down and which are pinned, per phase.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    duty_r = '0;
    duty_g = '0;
    duty_b = '0;
    case (p)
      3'd0: begin duty_r = M;     duty_g = r;              end
      3'd1: begin duty_r = M - r; duty_g = M;              end
      3'd2: begin duty_g = M;     duty_b = r;              end
      3'd3: begin duty_g = M - r; duty_b = M;              end
      3'd4: begin duty_r = r;     duty_b = M;              end
      3'd5: begin duty_r = M;     duty_b = M - r;          end
      default: ;
    endcase
  end

  // Sequencer FSM: prescaler, ramp/phase stepping, PWM counter and
  // registered pin/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments throughout so every register samples
      // pre-edge values, independent of statement order.
      state  <= IDLE;
      presc  <= '0;
      r      <= '0;
      p      <= '0;
      pc     <= '0;
      red    <= 1'b0;
      green  <= 1'b0;
      blue   <= 1'b0;
      active <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          presc <= '0;
          r     <= '0;
          p     <= '0;
          pc    <= '0;
          red   <= 1'b0;
          green <= 1'b0;
          blue  <= 1'b0;
          wrap  <= 1'b0;
          if (enable) begin
            state  <= RUN;
            active <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            // Dropping enable wins over any strobe in the same cycle.
            state  <= IDLE;
            active <= 1'b0;
            presc  <= '0;
            r      <= '0;
            p      <= '0;
            pc     <= '0;
            red    <= 1'b0;
            green  <= 1'b0;
            blue   <= 1'b0;
            wrap   <= 1'b0;
          end else begin
            red   <= (pc < duty_r);
            green <= (pc < duty_g);
            blue  <= (pc < duty_b);
            pc    <= (pc == PC_LAST) ? '0 : pc + WIDTH'(1);
            wrap  <= 1'b0;
            if (!hold) begin
              if (strobe) begin
                presc <= '0;
                if (r == M) begin
                  r <= '0;
                  if (p == 3'd5) begin
                    p    <= 3'd0;
                    wrap <= 1'b1;
                  end else begin
                    p <= p + 3'd1;
                  end
                end else begin
                  r <= r + WIDTH'(1);
                end
              end else begin
                presc <= presc + PW'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer with TIME=4, WIDTH=2 (M=3). A wheel model
// derives the expected outputs from elapsed run/advance cycle counts; a
// negedge process compares every output each cycle, and directed checks
// pin the model to hand-computed values.
module tb_rgb_fade_sequencer;

  localparam int TIME  = 4;
  localparam int WIDTH = 2;
  localparam int M     = 3;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       pause;
  logic       red, green, blue, active, wrap;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  rgb_fade_sequencer #(.TIME(TIME), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
`ifdef RGB_FADE_PAUSE_EN
    .pause  (pause),
`endif
    .red    (red),
    .green  (green),
    .blue   (blue),
    .phase  (phase),
    .active (active),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- wheel model ----------------
  bit running;
  int adv;   // cycles that advanced the wheel since entering run
  int cyc;   // cycles spent running (PWM time base)
  int m_r, m_g, m_b, m_wrap;

  function automatic int duty(input int ph, input int rr, input int ch);
    int t[6][3];
    t[0] = '{M,      rr,     0};
    t[1] = '{M - rr, M,      0};
    t[2] = '{0,      M,      rr};
    t[3] = '{0,      M - rr, M};
    t[4] = '{rr,     0,      M};
    t[5] = '{M,      0,      M - rr};
    return t[ph][ch];
  endfunction

  function automatic int model_phase();
    return running ? (adv / TIME / (M + 1)) % 6 : 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    int s, s2, rr, ph, pcv;
    if (!reset) begin
      running = 0; adv = 0; cyc = 0;
      m_r = 0; m_g = 0; m_b = 0; m_wrap = 0;
    end else if (!running) begin
      m_r = 0; m_g = 0; m_b = 0; m_wrap = 0;
      if (enable) begin
        running = 1; adv = 0; cyc = 0;
      end
    end else if (!enable) begin
      running = 0; adv = 0; cyc = 0;
      m_r = 0; m_g = 0; m_b = 0; m_wrap = 0;
    end else begin
      s   = adv / TIME;
      rr  = s % (M + 1);
      ph  = (s / (M + 1)) % 6;
      pcv = cyc % M;
      m_r = (pcv < duty(ph, rr, 0)) ? 1 : 0;
      m_g = (pcv < duty(ph, rr, 1)) ? 1 : 0;
      m_b = (pcv < duty(ph, rr, 2)) ? 1 : 0;
      cyc++;
      if (!pause) adv++;
      s2 = adv / TIME;
      m_wrap = (s2 != s && (s2 % (6 * (M + 1))) == 0) ? 1 : 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_red",    red,    m_r);
      check("cyc_green",  green,  m_g);
      check("cyc_blue",   blue,   m_b);
      check("cyc_wrap",   wrap,   m_wrap);
      check("cyc_active", active, running ? 1 : 0);
      check("cyc_phase",  phase,  model_phase());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int gcnt, wcnt, bcnt;
    reset  = 1'b0;
    enable = 1'b1;
    pause  = 1'b0;
    tick(3);
    chk_en = 1;
    check("rst_red",    red,    0);
    check("rst_green",  green,  0);
    check("rst_blue",   blue,   0);
    check("rst_wrap",   wrap,   0);
    check("rst_active", active, 0);
    check("rst_phase",  phase,  0);

    // Release reset; the next edge (k) starts the wheel.
    reset = 1'b1;
    tick(1);
    check("start_active", active, 1);
    check("start_phase",  phase,  0);
    check("start_red",    red,    0);
    tick(1);
    check("first_red",   red,   1);
    check("first_green", green, 0);
    check("first_blue",  blue,  0);

    // Phase 0, r = 2: green on 2 of 3 cycles (after edges k+10..k+12).
    tick(8);
    gcnt = 0;
    repeat (3) begin tick(1); gcnt += green; end
    check("green_duty_r2", gcnt, 2);
    tick(4);
    check("phase1_at16", phase, 1);

    // Through the first full wheel: one wrap, on the return to phase 0.
    wcnt = 0;
    repeat (80) begin tick(1); wcnt += wrap; end
    check("wrap_once",   wcnt,  1);
    check("wrap_at_96",  wrap,  1);
    check("phase0_at96", phase, 0);

    // Drop enable on the strobe edge k+148 (phase 3 of second wheel).
    tick(51);
    check("phase3_before_drop", phase, 3);
    enable = 1'b0;
    tick(1);
    check("drop_active", active, 0);
    check("drop_phase",  phase,  0);
    check("drop_red",    red,    0);
    check("drop_green",  green,  0);
    check("drop_blue",   blue,   0);

    // Re-enable restarts from phase 0, r = 0.
    enable = 1'b1;
    tick(1);
    check("reen_active", active, 1);
    check("reen_phase",  phase,  0);
    tick(16);
    check("reen_phase1", phase, 1);

    // Async reset mid-cycle in phase 4.
    tick(54);
    check("ph4_phase", phase, 4);
    check("ph4_blue",  blue,  1);
    #1 reset = 1'b0;
    #1;
    check("async_blue",   blue,   0);
    check("async_red",    red,    0);
    check("async_active", active, 0);
    check("async_phase",  phase,  0);
    tick(2);
    reset = 1'b1;

`ifdef RGB_FADE_PAUSE_EN
    // Restart, then pause at phase 2, r = 1 (n = 37).
    tick(1);
    tick(37);
    check("pre_pause_phase", phase, 2);
    pause = 1'b1;
    wcnt = 0;
    bcnt = 0;
    tick(2);
    repeat (18) begin tick(1); bcnt += blue; wcnt += wrap; end
    check("pause_phase",     phase, 2);
    check("pause_blue_duty", bcnt,  6);
    check("pause_no_wrap",   wcnt,  0);
    pause = 1'b0;
    tick(10);
    check("resume_phase", phase, 2);
`endif

    tick(5);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
